sprite_rom_arbiter: RTL and testbench

- Shares one synchronous-read sprite frame ROM port among NUM_REQ requesters, e.g. the pixel pipeline and the overlay/menu drawers.
- The ROM has a 19-bit read address and returns 24-bit palette-resolved colour on the clock edge after the address is presented.
- The block grants one requester per cycle using round-robin with bounded bursts. It drives the ROM address and returns the ROM data one cycle later, tagged with the requester ID.

---
 rtl/sprite_rom_arbiter.sv | 142 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin, burst-limited arbiter sharing one synchronous-read sprite ROM port.
// Define SPRITE_ARB_FIXED_PRIO_EN for a plain lowest-index-wins arbiter.
module sprite_rom_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int ADDR_W    = 19,
    parameter  int DATA_W    = 24,
    parameter  int MAX_BURST = 8,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o
);

    // Returns {found, index} of the first set request among count slots from start.
    function automatic logic [ID_W:0] f_search(input logic [NUM_REQ-1:0] req,
                                               input int start, input int count);
        logic           found;
        logic [ID_W-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = start + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && (i < count) && req[j[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = j[ID_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    logic [ID_W:0]   w_search;
    logic            w_found;
    logic [ID_W-1:0] w_idx;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        w_search = f_search(req_i, 0, NUM_REQ);
        w_found  = w_search[ID_W];
        w_idx    = w_search[ID_W-1:0];
    end
`else
    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t          r_state, w_state_next;
    logic [ID_W-1:0] r_owner, w_owner_next;
    logic [ID_W-1:0] r_rr_ptr, w_rr_next;
    logic [7:0]      r_burst_cnt, w_burst_next;
    logic [ID_W-1:0] w_owner_inc;

    assign w_owner_inc = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_search     = '0;
        w_found      = 1'b0;
        w_idx        = '0;
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr_ptr;
        w_burst_next = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                w_search = f_search(req_i, int'(r_rr_ptr), NUM_REQ);
                if (w_search[ID_W]) begin
                    w_found      = 1'b1;
                    w_idx        = w_search[ID_W-1:0];
                    w_owner_next = w_search[ID_W-1:0];
                    w_burst_next = 8'd1;
                    w_state_next = ST_OWN;
                end
            end
            default: begin
                if (req_i[r_owner] && (r_burst_cnt < 8'(MAX_BURST))) begin
                    w_found      = 1'b1;
                    w_idx        = r_owner;
                    w_burst_next = r_burst_cnt + 8'd1;
                end else begin
                    // Only the other requesters are searched; the owner is the fallback.
                    w_search = f_search(req_i, int'(w_owner_inc), NUM_REQ - 1);
                    if (w_search[ID_W]) begin
                        w_found      = 1'b1;
                        w_idx        = w_search[ID_W-1:0];
                        w_owner_next = w_search[ID_W-1:0];
                        w_burst_next = 8'd1;
                        w_rr_next    = w_owner_inc;
                    end else if (req_i[r_owner]) begin
                        w_found      = 1'b1;
                        w_idx        = r_owner;
                        w_burst_next = 8'd1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_rr_next    = w_owner_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_rr_ptr    <= w_rr_next;
            r_burst_cnt <= w_burst_next;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_found;
            r_rsp_id    <= w_idx;
        end
    end

    // Grants are masked while in reset so nothing reaches the ROM.
    assign gnt_o       = (w_found && Reset_n) ? (NUM_REQ'(1) << w_idx) : '0;
    assign rom_addr_o  = (w_found && Reset_n) ? addr_i[w_idx*ADDR_W +: ADDR_W] : '0;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_data_o  = rom_data_i;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized bench for sprite_rom_arbiter against a queue-free arithmetic arbitration model.
module tb_sprite_rom_arbiter;
    localparam int N   = 4;
    localparam int AW  = 19;
    localparam int DW  = 24;
    localparam int MB  = 8;
    localparam int IDW = 2;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N*AW-1:0] addr_i = '0;
    logic [N-1:0]    gnt_o;
    logic [AW-1:0]   rom_addr_o;
    logic [DW-1:0]   rom_data_i = '0;
    logic            rsp_valid_o;
    logic [IDW-1:0]  rsp_id_o;
    logic [DW-1:0]   rsp_data_o;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Model state: who owns the port, how long it has held it, where the search resumes.
    bit m_idle;
    int m_owner, m_rr, m_run;
    bit          exp_v;
    int          exp_id;
    logic [DW-1:0] exp_data;

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .rsp_valid_o(rsp_valid_o),
        .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h9E37_79B1;
        return p[28:5] ^ DW'(a);
    endfunction

    always @(posedge Clk) rom_data_i <= rom_f(rom_addr_o);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit has(input logic [N-1:0] r, input int k);
        return ((r >> k) & N'(1)) != '0;
    endfunction

    function automatic int m_search(input logic [N-1:0] r, input int start, input int count);
        for (int i = 0; i < count; i++)
            if (has(r, (start + i) % N)) return (start + i) % N;
        return -1;
    endfunction

    function automatic int model_grant(input logic [N-1:0] r);
        int g;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        g = m_search(r, 0, N);
`else
        if (m_idle) begin
            g = m_search(r, m_rr, N);
            if (g >= 0) begin m_idle = 0; m_owner = g; m_run = 1; end
        end else if (has(r, m_owner) && m_run < MB) begin
            g = m_owner;
            m_run++;
        end else begin
            g = m_search(r, (m_owner + 1) % N, N - 1);
            if (g >= 0) begin
                m_rr = (m_owner + 1) % N; m_owner = g; m_run = 1;
            end else if (has(r, m_owner)) begin
                g = m_owner; m_run = 1;
            end else begin
                m_idle = 1; m_rr = (m_owner + 1) % N;
            end
        end
`endif
        return g;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_owner = 0; m_rr = 0; m_run = 0; exp_v = 0; exp_id = 0; exp_data = '0;
    endtask

    function automatic logic [N*AW-1:0] rand_addr();
        logic [N*AW-1:0] a;
        for (int k = 0; k < N; k++) a[k*AW +: AW] = AW'($urandom);
        return a;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic run_cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        int g;
        logic [AW-1:0] ea;
        req_i  = r;
        addr_i = a;
        @(negedge Clk);
        chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_id", 32'(rsp_id_o), 32'(exp_id));
            chk("rsp_data", 32'(rsp_data_o), 32'(exp_data));
        end
        g  = model_grant(r);
        ea = (g >= 0) ? a[g*AW +: AW] : '0;
        chk("gnt", 32'(gnt_o), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("rom_addr", 32'(rom_addr_o), 32'(ea));
        $display("cyc=%0d req=%b gnt=%b addr=%05h rsp_v=%b id=%0d", cyc, r, gnt_o, rom_addr_o,
                 rsp_valid_o, rsp_id_o);
        exp_v    = (g >= 0);
        exp_id   = (g >= 0) ? g : 0;
        exp_data = rom_f(ea);
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic mid_reset();
        Reset_n = 1'b0;
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr_o), 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0]    r;
        logic [N*AW-1:0] a;
        model_reset();
        req_i  = '1;
        addr_i = rand_addr();
        #23;
        chk("reset_gnt", 32'(gnt_o), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id_o), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        run_cycle('1, rand_addr());
        run_cycle('0, rand_addr());
        run_cycle('0, rand_addr());

        a = rand_addr();
        a[1*AW +: AW] = 19'h00123;
        run_cycle(4'b0010, a);
        run_cycle(4'b0000, rand_addr());
        run_cycle(4'b0000, rand_addr());

        for (int i = 0; i < 40; i++) run_cycle(4'b0011, rand_addr());
        for (int i = 0; i < 20; i++) run_cycle(4'b1000, rand_addr());
        for (int i = 0; i < 20; i++) run_cycle(4'b0101, rand_addr());
        for (int i = 0; i < 12; i++) run_cycle(4'b1111, rand_addr());

        run_cycle(4'b0110, rand_addr());
        mid_reset();
        for (int i = 0; i < 4; i++) run_cycle(4'b1111, rand_addr());

        r = '1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 40) == 0) r = '0;
            run_cycle(r, rand_addr());
            if (c == 200) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
